wb_uart_array: RTL and testbench

//  Parametrised N-channel Wishbone UART replacing per-channel wb_uart instances in the LM32 SoC.

---
 rtl/wb_uart_array.sv | 244 ++++++++++++++++++++++++
 tb/tb_wb_uart_array.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_array.sv
// wb_uart_array: N-channel Wishbone UART, 16-byte channel stride, runtime divisor, TX hold+shift, RX FIFO.
// Optional build macro UART_ARRAY_LOOPBACK_EN adds per-channel TX->RX loopback on CTRL[4].
module wb_uart_array #(
  parameter int unsigned NCHAN      = 3,
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  output logic             wb_ack_o,
  input  logic [NCHAN-1:0] uart_rxd,
  output logic [NCHAN-1:0] uart_txd,
  output logic             intr
);
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0] RST_DIV = 16'(CLK_FREQ / BAUD);
`ifdef UART_ARRAY_LOOPBACK_EN
  localparam logic [4:0]  CTRL_MASK = 5'h17;
`else
  localparam logic [4:0]  CTRL_MASK = 5'h07;
`endif

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  logic                   ack_q, ack_d, intr_q, intr_d;
  logic [31:0]            dat_q, dat_d, rdat_c;
  logic                   acc_c;
  logic [3:0]             ch_c;
  logic [1:0]             reg_c;
  logic [NCHAN-1:0]       wr_stat_c, wr_data_c, wr_div_c, wr_ctrl_c, rd_data_c, irq_w;
  logic [NCHAN-1:0][4:0]  stat_w, ctrl_w;
  logic [NCHAN-1:0][15:0] div_w;
  logic [NCHAN-1:0][7:0]  head_w;
  logic                   unused_bits;

  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:8], wb_adr_i[1:0], wb_dat_i[31:16]};
  assign acc_c       = wb_stb_i & wb_cyc_i & ~ack_q;
  assign ch_c        = wb_adr_i[7:4];
  assign reg_c       = wb_adr_i[3:2];
  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_q;
  assign intr        = intr_q;

  // Bus decode: one strobe per channel/register, read mux, registered ack/data/irq
  always_comb begin
    wr_stat_c = '0;
    wr_data_c = '0;
    wr_div_c  = '0;
    wr_ctrl_c = '0;
    rd_data_c = '0;
    rdat_c    = '0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      if (ch_c == 4'(i)) begin
        wr_stat_c[i] = acc_c & wb_we_i & (reg_c == 2'd0);
        wr_data_c[i] = acc_c & wb_we_i & (reg_c == 2'd1);
        wr_div_c[i]  = acc_c & wb_we_i & (reg_c == 2'd2);
        wr_ctrl_c[i] = acc_c & wb_we_i & (reg_c == 2'd3);
        rd_data_c[i] = acc_c & ~wb_we_i & (reg_c == 2'd1);
        case (reg_c)
          2'd0:    rdat_c = {27'd0, stat_w[i]};
          2'd1:    rdat_c = {24'd0, stat_w[i][0] ? head_w[i] : 8'd0};
          2'd2:    rdat_c = {16'd0, div_w[i]};
          default: rdat_c = {27'd0, ctrl_w[i]};
        endcase
      end
    end
    ack_d  = acc_c;
    dat_d  = (acc_c & ~wb_we_i) ? rdat_c : 32'd0;
    intr_d = |irq_w;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_q  <= 1'b0;
      dat_q  <= 32'd0;
      intr_q <= 1'b0;
    end else begin
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      intr_q <= intr_d;
    end
  end

  for (genvar g = 0; g < NCHAN; g++) begin : g_ch
    logic [15:0] div_q, div_d, tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half_c;
    logic [4:0]  ctrl_q, ctrl_d;
    logic        ovr_q, ovr_d, ferr_q, ferr_d, hold_full_q, hold_full_d;
    logic [7:0]  hold_q, hold_d, rx_sh_q, rx_sh_d;
    logic [8:0]  tx_sh_q, tx_sh_d;
    logic [3:0]  tx_bit_q, tx_bit_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic        tx_line_q, tx_line_d, tx_load_c, tx_busy_c;
    logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_last_q, rx_last_d, rx_in_c;
    tx_state_e   tx_st_q, tx_st_d;
    rx_state_e   rx_st_q, rx_st_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        push_c, pop_c, fifo_we_c, empty_c, full_c;
    logic [7:0]  fifo_mem_q [FIFO_DEPTH];

`ifdef UART_ARRAY_LOOPBACK_EN
    assign rx_in_c     = ctrl_q[4] ? tx_line_q : uart_rxd[g];
    assign uart_txd[g] = tx_line_q | ctrl_q[4];
`else
    assign rx_in_c     = uart_rxd[g];
    assign uart_txd[g] = tx_line_q;
`endif

    assign empty_c   = (wr_ptr_q == rd_ptr_q);
    assign full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_c     = rd_data_c[g] & ~empty_c;
    assign tx_busy_c = hold_full_q | (tx_st_q != TX_IDLE);
    assign rx_half_c = {1'b0, rx_div_q[15:1]};
    assign stat_w[g] = {hold_full_q, ferr_q, ovr_q, tx_busy_c, ~empty_c};
    assign ctrl_w[g] = ctrl_q;
    assign div_w[g]  = div_q;
    assign head_w[g] = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign irq_w[g]  = (ctrl_q[0] & ~empty_c) | (ctrl_q[1] & ~tx_busy_c) | (ctrl_q[2] & (ovr_q | ferr_q));

    always_comb begin
      div_d = div_q;  ctrl_d = ctrl_q;  ovr_d = ovr_q;  ferr_d = ferr_q;
      hold_d = hold_q;  hold_full_d = hold_full_q;  tx_load_c = 1'b0;
      tx_st_d = tx_st_q;  tx_sh_d = tx_sh_q;  tx_bit_d = tx_bit_q;
      tx_cnt_d = tx_cnt_q;  tx_div_d = tx_div_q;  tx_line_d = tx_line_q;
      rx_s1_d = rx_in_c;  rx_s2_d = rx_s1_q;  rx_last_d = rx_s2_q;
      rx_st_d = rx_st_q;  rx_cnt_d = rx_cnt_q;  rx_div_d = rx_div_q;
      rx_bit_d = rx_bit_q;  rx_sh_d = rx_sh_q;  push_c = 1'b0;
      wr_ptr_d = wr_ptr_q;  rd_ptr_d = rd_ptr_q;

      if (wr_div_c[g])  div_d  = (wb_dat_i[15:0] < 16'd2) ? 16'd2 : wb_dat_i[15:0];
      if (wr_ctrl_c[g]) ctrl_d = wb_dat_i[4:0] & CTRL_MASK;
      if (wr_stat_c[g] & wb_dat_i[2]) ovr_d  = 1'b0;
      if (wr_stat_c[g] & wb_dat_i[3]) ferr_d = 1'b0;
      if (wr_data_c[g] & ~hold_full_q) begin
        hold_d      = wb_dat_i[7:0];
        hold_full_d = 1'b1;
      end

      // TX: start bit is bit 0, stop bit is bit 9; a waiting byte reloads with no gap
      case (tx_st_q)
        TX_IDLE: tx_load_c = hold_full_q;
        TX_SHIFT: begin
          tx_cnt_d = tx_cnt_q + 16'd1;
          if (tx_cnt_q == tx_div_q - 16'd1) begin
            tx_cnt_d = 16'd0;
            if (tx_bit_q == 4'd9) begin
              tx_load_c = hold_full_q;
              tx_st_d   = TX_IDLE;
            end else begin
              tx_line_d = tx_sh_q[0];
              tx_sh_d   = {1'b0, tx_sh_q[8:1]};
              tx_bit_d  = tx_bit_q + 4'd1;
            end
          end
        end
      endcase
      if (tx_load_c) begin
        tx_st_d     = TX_SHIFT;
        tx_line_d   = 1'b0;
        tx_sh_d     = {1'b1, hold_q};
        tx_bit_d    = 4'd0;
        tx_cnt_d    = 16'd0;
        tx_div_d    = div_q;
        hold_full_d = 1'b0;
      end

      // RX: verify start at half bit, then sample each bit centre
      case (rx_st_q)
        RX_IDLE: if (rx_last_q & ~rx_s2_q) begin
          rx_st_d  = RX_START;
          rx_cnt_d = 16'd0;
          rx_div_d = div_q;
        end
        RX_START: begin
          rx_cnt_d = rx_cnt_q + 16'd1;
          if (rx_cnt_q == rx_half_c - 16'd1) begin
            rx_cnt_d = 16'd0;
            rx_bit_d = 3'd0;
            rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          rx_cnt_d = rx_cnt_q + 16'd1;
          if (rx_cnt_q == rx_div_q - 16'd1) begin
            rx_cnt_d = 16'd0;
            rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
          end
        end
        RX_STOP: begin
          rx_cnt_d = rx_cnt_q + 16'd1;
          if (rx_cnt_q == rx_div_q - 16'd1) begin
            rx_st_d = RX_IDLE;
            if (rx_s2_q) push_c = 1'b1;
            else         ferr_d = 1'b1;
          end
        end
      endcase

      // A pop in the same cycle frees the slot for a push into a full FIFO
      fifo_we_c = push_c & (~full_c | pop_c);
      if (push_c & full_c & ~pop_c) ovr_d = 1'b1;
      if (fifo_we_c) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_c)     rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        div_q <= RST_DIV;  ctrl_q <= 5'd0;  ovr_q <= 1'b0;  ferr_q <= 1'b0;
        hold_q <= 8'd0;  hold_full_q <= 1'b0;
        tx_st_q <= TX_IDLE;  tx_sh_q <= 9'd0;  tx_bit_q <= 4'd0;
        tx_cnt_q <= 16'd0;  tx_div_q <= RST_DIV;  tx_line_q <= 1'b1;
        rx_s1_q <= 1'b1;  rx_s2_q <= 1'b1;  rx_last_q <= 1'b1;
        rx_st_q <= RX_IDLE;  rx_cnt_q <= 16'd0;  rx_div_q <= RST_DIV;
        rx_bit_q <= 3'd0;  rx_sh_q <= 8'd0;
        wr_ptr_q <= '0;  rd_ptr_q <= '0;
      end else begin
        div_q <= div_d;  ctrl_q <= ctrl_d;  ovr_q <= ovr_d;  ferr_q <= ferr_d;
        hold_q <= hold_d;  hold_full_q <= hold_full_d;
        tx_st_q <= tx_st_d;  tx_sh_q <= tx_sh_d;  tx_bit_q <= tx_bit_d;
        tx_cnt_q <= tx_cnt_d;  tx_div_q <= tx_div_d;  tx_line_q <= tx_line_d;
        rx_s1_q <= rx_s1_d;  rx_s2_q <= rx_s2_d;  rx_last_q <= rx_last_d;
        rx_st_q <= rx_st_d;  rx_cnt_q <= rx_cnt_d;  rx_div_q <= rx_div_d;
        rx_bit_q <= rx_bit_d;  rx_sh_q <= rx_sh_d;
        wr_ptr_q <= wr_ptr_d;  rd_ptr_q <= rd_ptr_d;
      end
    end

    always_ff @(posedge clk) begin
      if (fifo_we_c) fifo_mem_q[wr_ptr_q[AW-1:0]] <= rx_sh_q;
    end
  end

endmodule

// File: tb/tb_wb_uart_array.sv
// Self-checking bench for wb_uart_array: register access, TX framing, RX FIFO, errors, irq, loopback.
module tb_wb_uart_array;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o, intr;
  logic [2:0]  uart_rxd, uart_txd;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  rx_exp_q[$];
  logic        tx_exp_q[$];

  always #5 clk = ~clk;

  wb_uart_array #(.NCHAN(3), .CLK_FREQ(100000000), .BAUD(9600), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o), .uart_rxd(uart_rxd), .uart_txd(uart_txd), .intr(intr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wb_xfer(input logic we, input int ch, input int rg, input logic [31:0] wdat,
                         output logic [31:0] rdat);
    int n = 0;
    @(negedge clk);
    wb_adr_i = {24'd0, 4'(ch), 2'(rg), 2'b00};
    wb_dat_i = wdat;
    wb_we_i  = we;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    do begin @(posedge clk); #1; n++; end while (!wb_ack_o && n < 20);
    if (!wb_ack_o) check("ack_timeout", 32'(wb_ack_o), 32'd1);
    rdat     = wb_dat_o;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wb_write(input int ch, input int rg, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, ch, rg, d, dummy);
  endtask

  task automatic wb_read(input int ch, input int rg, output logic [31:0] d);
    wb_xfer(1'b0, ch, rg, 32'd0, d);
  endtask

  task automatic push_tx_frame(input logic [7:0] b);
    tx_exp_q.push_back(1'b0);
    for (int k = 0; k < 8; k++) tx_exp_q.push_back(b[k]);
    tx_exp_q.push_back(1'b1);
  endtask

  // Waits for a start bit, then samples the centre of each of nbits bits at 16 clk/bit
  task automatic tx_monitor(input int ch, input int nbits);
    int n = 0;
    while (uart_txd[ch] && n < 600) begin @(posedge clk); #1; n++; end
    if (uart_txd[ch]) begin
      check("tx_start_timeout", 32'(uart_txd[ch]), 32'd0);
      return;
    end
    cycles(8);
    for (int k = 0; k < nbits; k++) begin
      check($sformatf("tx_bit%0d", k), 32'(uart_txd[ch]), 32'(tx_exp_q.pop_front()));
      if (k < nbits - 1) cycles(16);
    end
  endtask

  task automatic send_frame(input int ch, input logic [7:0] b, input logic stop_ok);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      uart_rxd[ch] = f[k];
      repeat (15) @(negedge clk);
    end
    @(negedge clk);
    uart_rxd[ch] = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation timeout after %0d tests", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          acks;
    rst = 1'b0;  uart_rxd = 3'b111;  wb_adr_i = '0;  wb_dat_i = '0;
    wb_sel_i = 4'hF;  wb_we_i = 1'b0;  wb_stb_i = 1'b0;  wb_cyc_i = 1'b0;

    cycles(2);
    for (int k = 0; k < 3; k++) begin
      check("rst_txd", 32'(uart_txd), 32'h7);
      cycles(1);
    end
    check("rst_ack", 32'(wb_ack_o), 32'd0);
    check("rst_intr", 32'(intr), 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    wb_read(0, 0, d);  check("rst_status", d, 32'h0);
    wb_read(0, 2, d);  check("rst_div", d, 32'd10416);
    wb_read(2, 3, d);  check("rst_ctrl", d, 32'h0);

    // Held strobe: ack pulses with an idle cycle between
    @(negedge clk);
    wb_adr_i = 32'h0;  wb_we_i = 1'b0;  wb_stb_i = 1'b1;  wb_cyc_i = 1'b1;
    acks = 0;
    repeat (4) begin @(posedge clk); #1; acks += int'(wb_ack_o); end
    wb_stb_i = 1'b0;  wb_cyc_i = 1'b0;
    check("ack_pulses", 32'(acks), 32'd2);

    wb_write(0, 2, 32'd1);   wb_read(0, 2, d);  check("div_min", d, 32'd2);
    wb_write(1, 2, 32'd16);  wb_read(1, 2, d);  check("div_wr", d, 32'd16);
    wb_write(3, 2, 32'd55);  wb_read(3, 2, d);  check("oob_read", d, 32'd0);
    wb_read(15, 0, d);       check("oob_status", d, 32'd0);
    wb_write(0, 3, 32'h18);  wb_read(0, 3, d);
`ifdef UART_ARRAY_LOOPBACK_EN
    check("ctrl_mask", d, 32'h10);
`else
    check("ctrl_mask", d, 32'h00);
`endif
    wb_write(0, 3, 32'h0);

    // Single TX frame
    push_tx_frame(8'hA5);
    fork
      tx_monitor(1, 10);
      begin
        wb_write(1, 1, 32'hA5);
        cycles(3);
        wb_read(1, 0, d);  check("tx_busy", d, 32'h2);
      end
    join
    cycles(12);
    wb_read(1, 0, d);  check("tx_idle", d, 32'h0);

    // Back-to-back frames; third write lands on a full holding register
    push_tx_frame(8'h11);
    push_tx_frame(8'h22);
    fork
      tx_monitor(1, 20);
      begin
        wb_write(1, 1, 32'h11);
        cycles(3);
        wb_write(1, 1, 32'h22);
        wb_write(1, 1, 32'h33);
        wb_read(1, 0, d);  check("tx_hold_full", d, 32'h12);
      end
    join
    cycles(12);
    wb_read(1, 0, d);  check("tx_drop", d, 32'h0);

    // Single RX byte
    wb_write(2, 2, 32'd16);
    rx_exp_q.push_back(8'h3C);
    send_frame(2, 8'h3C, 1'b1);
    wb_read(2, 0, d);  check("rx_avail", d, 32'h1);
    wb_read(2, 1, d);  check("rx_data", d, 32'(rx_exp_q.pop_front()));
    wb_read(2, 0, d);  check("rx_empty_status", d, 32'h0);
    wb_read(2, 1, d);  check("rx_empty_data", d, 32'h0);

    // FIFO overflow
    for (int i = 0; i < 17; i++) begin
      if (i < 16) rx_exp_q.push_back(8'(8'h40 + i));
      send_frame(2, 8'(8'h40 + i), 1'b1);
    end
    wb_read(2, 0, d);  check("ovr_status", d, 32'h5);
    for (int i = 0; i < 16; i++) begin
      wb_read(2, 1, d);
      check($sformatf("fifo_rd%0d", i), d, 32'(rx_exp_q.pop_front()));
    end
    wb_read(2, 0, d);  check("ovr_sticky", d, 32'h4);
    wb_write(2, 0, 32'h4);
    wb_read(2, 0, d);  check("ovr_clear", d, 32'h0);

    // Frame error and error interrupt
    send_frame(2, 8'h77, 1'b0);
    wb_read(2, 0, d);  check("ferr_status", d, 32'h8);
    wb_write(2, 3, 32'h4);
    cycles(2);         check("err_intr", 32'(intr), 32'd1);
    wb_read(2, 3, d);  check("ctrl_rd", d, 32'h4);
    wb_write(2, 0, 32'h8);
    cycles(2);         check("err_intr_clr", 32'(intr), 32'd0);
    wb_read(2, 0, d);  check("ferr_clear", d, 32'h0);
    wb_write(2, 3, 32'h0);

    // TX-idle interrupt
    wb_write(1, 3, 32'h2);
    cycles(2);         check("tx_intr", 32'(intr), 32'd1);
    wb_write(1, 3, 32'h0);
    cycles(2);         check("tx_intr_off", 32'(intr), 32'd0);

`ifdef UART_ARRAY_LOOPBACK_EN
    wb_write(0, 2, 32'd16);
    wb_write(0, 3, 32'h10);
    rx_exp_q.push_back(8'h5A);
    wb_write(0, 1, 32'h5A);
    acks = 0;
    repeat (220) begin @(posedge clk); #1; if (!uart_txd[0]) acks++; end
    check("lb_txd_held", 32'(acks), 32'd0);
    wb_read(0, 0, d);  check("lb_avail", d, 32'h1);
    wb_read(0, 1, d);  check("lb_data", d, 32'(rx_exp_q.pop_front()));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
